pc_ir_regs: RTL and testbench
=============================

# pc_ir_regs

State-holding front end of the multicycle MIPS datapath: the program counter, instruction register, memory-data register and the non-architectural A, B and ALUOut holding registers. It sits directly upstream of the control unit, supplying the `op` and `func` fields it decodes. It also consumes that unit's `IorD`, `IRWrite`, `PCEn` and `PCSrc` outputs to sequence fetch and PC update.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `IorD`  in  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  in  1  load IR from `mem_rdata`.
- `PCEn`  in  1  load PC from the PCSrc mux (branch gating already resolved upstream).
- `PCSrc`  in  2  next-PC select: 00 `alu_result`, 01 ALUOut, 10 jump target, 11 reserved.
- `alu_result`  in  32  combinational ALU output.
- `rd1`, `rd2`  in  32 each  register-file read ports.
- `mem_rdata`  in  32  unified memory read data.
- `mem_addr`  out  32  unified memory address.
- `pc`  out  32  current PC.
- `op`, `func`  out  6 each  IR[31:26], IR[5:0].
- `rs`, `rt`, `rd`  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- `signimm`  out  32  sign-extended IR[15:0].
- `data_reg`, `a_reg`, `b_reg`, `aluout`  out  32 each  holding registers.
- `pc_misalign`  out  1  sticky flag, PC loaded with nonzero [1:0].
- `instr_count`  out  32  fetched-instruction counter (see Configuration).

## Operation
- `mem_addr` = `IorD` ? `aluout` : `pc`; combinational, no register.
- IR loads `mem_rdata` only when `IRWrite`=1; otherwise holds. `op`/`func`/fields/`signimm` are combinational slices of IR.
- `data_reg` loads `mem_rdata`; `a_reg` loads `rd1`; `b_reg` loads `rd2`; `aluout` loads `alu_result`. All four load every cycle, with no enable.
- PC loads when `PCEn`=1. Source by `PCSrc`:
  - 00: `alu_result`
  - 01: `aluout`
  - 10: {`pc`[31:28], IR[25:0], 2'b00}, using the PC and IR values from before the edge
  - 11: PC holds
- `pc_misalign` sets on any PC load whose value has [1:0]≠0. It clears only on `reset`.
- Reset has priority over every load. On reset:
  - `pc`=`RESET_PC`
  - IR, `data_reg`, `a_reg`, `b_reg`, `aluout`, `instr_count` = 0
  - `pc_misalign`=0

## Timing
- All registers capture at the rising edge. Loaded values are visible the cycle after the enable is sampled.
- Fetch cycle (`IorD`=0, `IRWrite`=1, `PCEn`=1, `PCSrc`=00) in one edge:
  - IR captures the word at the old PC.
  - PC captures `alu_result` (PC+4).
  - No read-after-write hazard.
- `IRWrite` and `PCEn` with `PCSrc`=10 in the same cycle: the jump target uses the old IR, not the incoming word.
- Reset asserted mid-instruction: all state returns to reset values at that edge. In-flight loads are discarded.
- PC wraps modulo 2^32; there is no overflow detection.

## Configuration
- `PC_IR_INSTR_COUNT_EN` defined:
  - `instr_count` increments by 1 on each edge with `IRWrite`=1 and `reset`=0.
  - Wraps 32'hFFFF_FFFF→0.
- Not defined: no counter register; `instr_count` tied to 0.

## Test plan
- Reset with `RESET_PC`=32'h0000_0100 → `pc`=0x100, IR=0, `mem_addr`=0x100, `pc_misalign`=0.
- Fetch: `mem_rdata`=32'h8C43_0004, `alu_result`=0x104, fetch controls for one cycle → IR=0x8C430004, `op`=6'h23, `rt`=3, `signimm`=4, `pc`=0x104.
- Jump: IR=32'h0800_0040, `pc`=0x104, `PCEn`=1, `PCSrc`=10 → `pc`=0x100. Repeat with `IRWrite`=1 and a new `mem_rdata` in the same cycle → still 0x100.
- `IorD`=1 with `aluout`=0x2000 → `mem_addr`=0x2000. Next cycle `data_reg` = that cycle's `mem_rdata`.
- `PCEn`=1, `alu_result`=0x0000_0106 → `pc`=0x106 and `pc_misalign`=1. The flag stays 1 after a later aligned load; reset clears it.
- With `PC_IR_INSTR_COUNT_EN`: 3 `IRWrite` pulses → `instr_count`=3. Assert reset mid-sequence → 0. Without the macro → 0 throughout.

Source files
------------

// File: rtl/pc_ir_regs_if.sv
// ============================================================================
// Module : pc_ir_regs_if
// Brief  : Bundle of control, datapath and register-view signals for pc_ir_regs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_ir_regs_if;
    logic        IorD;
    logic        IRWrite;
    logic        PCEn;
    logic [1:0]  PCSrc;
    logic [31:0] alu_result;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] mem_rdata;

    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] signimm;
    logic [31:0] data_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] aluout;
    logic        pc_misalign;
    logic [31:0] instr_count;

    modport master (
        output IorD, IRWrite, PCEn, PCSrc, alu_result, rd1, rd2, mem_rdata,
        input  mem_addr, pc, op, func, rs, rt, rd, signimm,
               data_reg, a_reg, b_reg, aluout, pc_misalign, instr_count
    );

    modport slave (
        input  IorD, IRWrite, PCEn, PCSrc, alu_result, rd1, rd2, mem_rdata,
        output mem_addr, pc, op, func, rs, rt, rd, signimm,
               data_reg, a_reg, b_reg, aluout, pc_misalign, instr_count
    );
endinterface

`default_nettype wire

// File: rtl/pc_ir_regs.sv
// ============================================================================
// Module : pc_ir_regs
// Brief  : Multicycle MIPS PC/IR/MDR/A/B/ALUOut registers. Optional
//          fetched-instruction counter enabled by macro PC_IR_INSTR_COUNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_ir_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic      clk,
    input  wire logic      reset,
    pc_ir_regs_if.slave    bus
);

    localparam logic [1:0] c_SRC_ALU  = 2'b00;
    localparam logic [1:0] c_SRC_OUT  = 2'b01;
    localparam logic [1:0] c_SRC_JUMP = 2'b10;

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_data;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic        r_misalign;

    logic [31:0] w_pc_next;
    logic        w_pc_load;

    // Jump target is built from pre-edge PC and IR, so a concurrent IR load
    // never leaks into the target.
    always_comb begin
        w_pc_load = bus.PCEn;
        w_pc_next = r_pc;
        case (bus.PCSrc)
            c_SRC_ALU:  w_pc_next = bus.alu_result;
            c_SRC_OUT:  w_pc_next = r_aluout;
            c_SRC_JUMP: w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            default: begin
                w_pc_next = r_pc;
                w_pc_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= 32'd0;
            r_data     <= 32'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_aluout   <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_data   <= bus.mem_rdata;
            r_a      <= bus.rd1;
            r_b      <= bus.rd2;
            r_aluout <= bus.alu_result;
            if (bus.IRWrite) begin
                r_ir <= bus.mem_rdata;
            end
            if (w_pc_load) begin
                r_pc <= w_pc_next;
                if (w_pc_next[1:0] != 2'b00) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

`ifdef PC_IR_INSTR_COUNT_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= 32'd0;
        end else if (bus.IRWrite) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign bus.instr_count = r_instr_count;
`else
    assign bus.instr_count = 32'd0;
`endif

    assign bus.mem_addr    = bus.IorD ? r_aluout : r_pc;
    assign bus.pc          = r_pc;
    assign bus.op          = r_ir[31:26];
    assign bus.rs          = r_ir[25:21];
    assign bus.rt          = r_ir[20:16];
    assign bus.rd          = r_ir[15:11];
    assign bus.func        = r_ir[5:0];
    assign bus.signimm     = {{16{r_ir[15]}}, r_ir[15:0]};
    assign bus.data_reg    = r_data;
    assign bus.a_reg       = r_a;
    assign bus.b_reg       = r_b;
    assign bus.aluout      = r_aluout;
    assign bus.pc_misalign = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_ir_regs.sv
// ============================================================================
// Module : tb_pc_ir_regs
// Brief  : Directed table-driven bench for pc_ir_regs (RESET_PC = 0x100).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_ir_regs;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
    localparam int          c_NV       = 13;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;

    always #5 clk = ~clk;

    pc_ir_regs_if bus ();

    pc_ir_regs #(.RESET_PC(c_RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        rst;
        logic        iord;
        logic        irw;
        logic        pcen;
        logic [1:0]  pcsrc;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] e_pc;
        logic [31:0] e_ir;
        logic [31:0] e_addr;
        logic        e_mis;
    } vec_t;

    vec_t vecs [c_NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic iord, input logic irw, input logic pcen,
                       input logic [1:0] pcsrc, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] d1, input logic [31:0] d2);
        @(negedge clk);
        reset          = r;
        bus.IorD       = iord;
        bus.IRWrite    = irw;
        bus.PCEn       = pcen;
        bus.PCSrc      = pcsrc;
        bus.alu_result = alu;
        bus.mem_rdata  = mem;
        bus.rd1        = d1;
        bus.rd2        = d2;
        @(posedge clk);
        #1;
`ifdef PC_IR_INSTR_COUNT_EN
        if (r) exp_cnt = 32'd0;
        else if (irw) exp_cnt = exp_cnt + 32'd1;
`else
        exp_cnt = 32'd0;
`endif
    endtask

    initial begin
        logic [31:0] ir_v;
        logic [31:0] d1, d2;

        reset = 1'b1;
        bus.IorD = 1'b0; bus.IRWrite = 1'b0; bus.PCEn = 1'b0; bus.PCSrc = 2'b00;
        bus.alu_result = '0; bus.rd1 = '0; bus.rd2 = '0; bus.mem_rdata = '0;

        //            rst  iord irw  pcen src    alu            mem            e_pc           e_ir           e_addr         mis
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,2'b00,32'h0000_0000,32'h0000_0000,32'h0000_0100,32'h0000_0000,32'h0000_0100,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b1,1'b1,2'b00,32'h0000_0104,32'h8C43_0004,32'h0000_0104,32'h8C43_0004,32'h0000_0104,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,2'b00,32'h0000_2000,32'h0800_0040,32'h0000_0104,32'h0800_0040,32'h0000_0104,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,2'b10,32'h0000_3000,32'h1234_5678,32'h0000_0100,32'h0800_0040,32'h0000_3000,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,2'b10,32'h0000_0000,32'hDEAD_BEEF,32'h0000_0100,32'hDEAD_BEEF,32'h0000_0100,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,2'b01,32'h0000_0106,32'h0000_0000,32'h0000_0000,32'hDEAD_BEEF,32'h0000_0000,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,2'b00,32'h0000_0106,32'h0000_0000,32'h0000_0106,32'hDEAD_BEEF,32'h0000_0106,1'b1};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b1,2'b00,32'h0000_0200,32'h0000_0000,32'h0000_0200,32'hDEAD_BEEF,32'h0000_0200,1'b1};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,2'b11,32'h0000_0300,32'h0000_0000,32'h0000_0200,32'hDEAD_BEEF,32'h0000_0200,1'b1};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,2'b00,32'h0000_0500,32'h0000_0000,32'h0000_0200,32'hDEAD_BEEF,32'h0000_0200,1'b1};
        vecs[10] = '{1'b1,1'b1,1'b1,1'b1,2'b00,32'h0000_0700,32'hCAFE_F00D,32'h0000_0100,32'h0000_0000,32'h0000_0000,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b1,1'b1,2'b00,32'hFFFF_FFFC,32'h0800_0003,32'hFFFF_FFFC,32'h0800_0003,32'hFFFF_FFFC,1'b0};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b1,2'b10,32'h0000_0000,32'h0000_0000,32'hF000_000C,32'h0800_0003,32'hF000_000C,1'b0};

        for (int i = 0; i < c_NV; i++) begin
            d1 = 32'hA000_0000 + 32'(i);
            d2 = 32'hB000_0000 + 32'(i);
            cyc(vecs[i].rst, vecs[i].iord, vecs[i].irw, vecs[i].pcen, vecs[i].pcsrc,
                vecs[i].alu, vecs[i].mem, d1, d2);
            ir_v = vecs[i].e_ir;
            check($sformatf("v%0d pc", i),       bus.pc, vecs[i].e_pc);
            check($sformatf("v%0d fields", i),
                  {6'd0, bus.op, bus.rs, bus.rt, bus.rd, bus.func},
                  {6'd0, ir_v[31:26], ir_v[25:21], ir_v[20:16], ir_v[15:11], ir_v[5:0]});
            check($sformatf("v%0d signimm", i),  bus.signimm, {{16{ir_v[15]}}, ir_v[15:0]});
            check($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].e_addr);
            check($sformatf("v%0d misalign", i), {31'd0, bus.pc_misalign}, {31'd0, vecs[i].e_mis});
            check($sformatf("v%0d data_reg", i), bus.data_reg, vecs[i].rst ? 32'd0 : vecs[i].mem);
            check($sformatf("v%0d a_reg", i),    bus.a_reg,    vecs[i].rst ? 32'd0 : d1);
            check($sformatf("v%0d b_reg", i),    bus.b_reg,    vecs[i].rst ? 32'd0 : d2);
            check($sformatf("v%0d aluout", i),   bus.aluout,   vecs[i].rst ? 32'd0 : vecs[i].alu);
            check($sformatf("v%0d instr_count", i), bus.instr_count, exp_cnt);
        end

        // IorD=1 selects ALUOut combinationally; data_reg takes that cycle's read.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_2000, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        bus.IorD      = 1'b1;
        bus.mem_rdata = 32'h55AA_55AA;
        #1;
        check("iord mem_addr", bus.mem_addr, 32'h0000_2000);
        @(posedge clk);
        #1;
        check("iord data_reg", bus.data_reg, 32'h55AA_55AA);

        // Counter: three fetch pulses, one more, then reset mid-sequence.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        check("cnt reset", bus.instr_count, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h1111_0000 + 32'(k), 32'h0, 32'h0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        end
`ifdef PC_IR_INSTR_COUNT_EN
        check("cnt three", bus.instr_count, 32'd3);
`else
        check("cnt three", bus.instr_count, 32'd0);
`endif
        check("cnt model", bus.instr_count, exp_cnt);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h2222_0000, 32'h0, 32'h0);
        check("cnt four", bus.instr_count, exp_cnt);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0000_0400, 32'h3333_0000, 32'h0, 32'h0);
        check("cnt mid reset", bus.instr_count, 32'd0);
        check("pc mid reset", bus.pc, c_RESET_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
